// File: rtl/prng_spike_encoder.sv
// Rate-coded spike encoder: one PRNG sample per handshake, spike when sample < rate,
// then a programmable refractory period. Define SPIKE_CNT_SAT_EN for a saturating spike counter.
module prng_spike_encoder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned REF_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] rnd_data,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    input  logic [DATA_W-1:0] rate,
    input  logic [REF_W-1:0]  refrac,
    input  logic              clr_cnt,
    output logic              spike,
    output logic              busy,
    output logic [CNT_W-1:0]  spike_count
);

    typedef enum logic [1:0] {StIdle, StSample, StRefrac} state_e;

    state_e             state_q, state_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic               spike_q, spike_d;
    logic [CNT_W-1:0]   spike_count_q, spike_count_d;
    logic               hs;
    logic               hit;

    assign rnd_ready   = en && (state_q == StSample);
    assign hs          = rnd_valid && rnd_ready;
    assign hit         = hs && (rnd_data < rate);
    assign spike       = spike_q;
    assign busy        = (state_q == StRefrac);
    assign spike_count = spike_count_q;

    always_comb begin
        state_d   = state_q;
        ref_cnt_d = ref_cnt_q;
        spike_d   = hit;
        if (!en) begin
            state_d   = StIdle;
            ref_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StSample;
                StSample: begin
                    if (hit && (refrac != '0)) begin
                        state_d   = StRefrac;
                        ref_cnt_d = refrac;
                    end
                end
                StRefrac: begin
                    // Leaving on the count==1 cycle gives exactly refrac cycles of ready low.
                    if (ref_cnt_q <= REF_W'(1)) begin
                        state_d   = StSample;
                        ref_cnt_d = '0;
                    end else begin
                        ref_cnt_d = ref_cnt_q - REF_W'(1);
                    end
                end
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        spike_count_d = spike_count_q;
        if (clr_cnt) begin
            // A spike coinciding with a clear is still counted.
            spike_count_d = hit ? CNT_W'(1) : '0;
        end else if (hit) begin
`ifdef SPIKE_CNT_SAT_EN
            if (spike_count_q != '1) begin
                spike_count_d = spike_count_q + CNT_W'(1);
            end
`else
            spike_count_d = spike_count_q + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ref_cnt_q     <= '0;
            spike_q       <= 1'b0;
            spike_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ref_cnt_q     <= ref_cnt_d;
            spike_q       <= spike_d;
            spike_count_q <= spike_count_d;
        end
    end

endmodule

// File: tb/tb_prng_spike_encoder.sv
// Directed self-checking bench for prng_spike_encoder, built with a 4-bit spike counter
// so wrap/saturation is reachable.
module tb_prng_spike_encoder;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned RW = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] rnd_data;
    logic          rnd_valid;
    logic          rnd_ready;
    logic [DW-1:0] rate;
    logic [RW-1:0] refrac;
    logic          clr_cnt;
    logic          spike;
    logic          busy;
    logic [CW-1:0] spike_count;

    int checks = 0;
    int errors = 0;

    prng_spike_encoder #(
        .DATA_W (DW),
        .CNT_W  (CW),
        .REF_W  (RW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .rate        (rate),
        .refrac      (refrac),
        .clr_cnt     (clr_cnt),
        .spike       (spike),
        .busy        (busy),
        .spike_count (spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; rnd_data = '0; rnd_valid = 1'b0;
        rate = '0; refrac = '0; clr_cnt = 1'b0;
        tick(); tick();
        checks++;
        if ({spike, busy, rnd_ready, spike_count} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got spike=%b busy=%b ready=%b cnt=%0d, want all 0",
                     spike, busy, rnd_ready, spike_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] data [4];
        logic          exp  [4];
        data = '{8'h10, 8'h90, 8'h7F, 8'h80};
        exp  = '{1'b1, 1'b0, 1'b1, 1'b0};
        en = 1'b1; rate = 8'h80; refrac = '0; rnd_valid = 1'b1; rnd_data = 8'h10;
        tick();
        checks++;
        if (rnd_ready !== 1'b1 || spike !== 1'b0) begin
            errors++;
            $display("FAIL basic_enter_sample: got ready=%b spike=%b, want 1 0", rnd_ready, spike);
        end
        for (int i = 0; i < 4; i++) begin
            rnd_data = data[i];
            tick();
            checks++;
            if (spike !== exp[i]) begin
                errors++;
                $display("FAIL basic_spike[%0d]: got %b, want %b", i, spike, exp[i]);
            end
        end
        rnd_valid = 1'b0;
        tick();
        checks++;
        if (spike_count !== 4'd2 || spike !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: got cnt=%0d spike=%b, want 2 0", spike_count, spike);
        end
    endtask

    task automatic test_refrac();
        rate = 8'hFF; refrac = 4'd3; rnd_data = 8'h00; rnd_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (spike !== (k % 4 == 0) || busy !== (k % 4 != 3) || rnd_ready !== (k % 4 == 3)) begin
                errors++;
                $display("FAIL refrac_cycle[%0d]: got spike=%b busy=%b ready=%b, want %b %b %b",
                         k, spike, busy, rnd_ready, k % 4 == 0, k % 4 != 3, k % 4 == 3);
            end
        end
        rnd_valid = 1'b0; refrac = '0;
        tick();
        checks++;
        if (spike_count !== 4'd5) begin
            errors++;
            $display("FAIL refrac_count: got %0d, want 5", spike_count);
        end
    endtask

    task automatic test_rate_bounds();
        int bad = 0;
        rate = 8'h00; rnd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rnd_data = DW'($urandom_range(0, 255));
            tick();
            if (spike !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || spike_count !== 4'd5) begin
            errors++;
            $display("FAIL rate_zero: got %0d spikes cnt=%0d, want 0 spikes cnt=5", bad, spike_count);
        end
        rate = 8'hFF; rnd_data = 8'hFF;
        tick();
        checks++;
        if (spike !== 1'b0) begin
            errors++;
            $display("FAIL rate_max_allones: got spike=%b, want 0", spike);
        end
        rnd_data = 8'hFE;
        tick();
        checks++;
        if (spike !== 1'b1 || spike_count !== 4'd6) begin
            errors++;
            $display("FAIL rate_max_fe: got spike=%b cnt=%0d, want 1 6", spike, spike_count);
        end
        rnd_valid = 1'b0;
        tick();
    endtask

    task automatic test_en_drop();
        refrac = 4'd7; rate = 8'hFF; rnd_data = 8'h00; rnd_valid = 1'b1;
        tick();
        checks++;
        if (spike !== 1'b1 || busy !== 1'b1 || rnd_ready !== 1'b0) begin
            errors++;
            $display("FAIL en_refrac_entry: got spike=%b busy=%b ready=%b, want 1 1 0",
                     spike, busy, rnd_ready);
        end
        rnd_valid = 1'b0;
        tick(); tick();
        en = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || rnd_ready !== 1'b0 || spike !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_idle: got busy=%b ready=%b spike=%b, want 0 0 0",
                     busy, rnd_ready, spike);
        end
        en = 1'b1;
        checks++;
        if (rnd_ready !== 1'b0) begin
            errors++;
            $display("FAIL en_idle_ready: got %b, want 0", rnd_ready);
        end
        tick();
        checks++;
        if (rnd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_resume_sample: got ready=%b busy=%b, want 1 0", rnd_ready, busy);
        end
        tick();
        checks++;
        if (rnd_ready !== 1'b1 || busy !== 1'b0 || spike_count !== 4'd7) begin
            errors++;
            $display("FAIL en_no_refrac_resume: got ready=%b busy=%b cnt=%0d, want 1 0 7",
                     rnd_ready, busy, spike_count);
        end
        refrac = '0;
    endtask

    task automatic test_clr();
        clr_cnt = 1'b1; rnd_valid = 1'b0;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (spike_count !== 4'd0) begin
            errors++;
            $display("FAIL clr_alone_first: got %0d, want 0", spike_count);
        end
        rate = 8'hFF; rnd_data = 8'h00; rnd_valid = 1'b1;
        repeat (5) tick();
        checks++;
        if (spike_count !== 4'd5) begin
            errors++;
            $display("FAIL clr_preload: got %0d, want 5", spike_count);
        end
        clr_cnt = 1'b1;
        tick();
        checks++;
        if (spike_count !== 4'd1 || spike !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_inc: got cnt=%0d spike=%b, want 1 1", spike_count, spike);
        end
        rnd_valid = 1'b0;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (spike_count !== 4'd0) begin
            errors++;
            $display("FAIL clr_alone: got %0d, want 0", spike_count);
        end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] exp_final;
`ifdef SPIKE_CNT_SAT_EN
        exp_final = 4'd15;
`else
        exp_final = 4'd1;
`endif
        rate = 8'hFF; rnd_data = 8'h00; rnd_valid = 1'b1;
        repeat (15) tick();
        checks++;
        if (spike_count !== 4'd15) begin
            errors++;
            $display("FAIL wrap_at15: got %0d, want 15", spike_count);
        end
        repeat (2) tick();
        rnd_valid = 1'b0;
        checks++;
        if (spike_count !== exp_final) begin
            errors++;
            $display("FAIL wrap_17: got %0d, want %0d", spike_count, exp_final);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        refrac = 4'd7; rate = 8'hFF; rnd_data = 8'h00; rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({spike, busy, rnd_ready, spike_count} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_refrac: got spike=%b busy=%b ready=%b cnt=%0d, want all 0",
                     spike, busy, rnd_ready, spike_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        rnd_valid = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        rnd_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (spike !== 1'b0 || spike_count !== 4'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_handshake: got %0d bad cycles, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_refrac();
        test_rate_bounds();
        test_en_drop();
        test_clr();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
